// File: rtl/pipeline_pkg.sv
// Shared MEM-stage definitions: datapath widths, store-buffer depth,
// the buffer entry layout and word-address extraction.
package pipeline_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // Stores and loads are word-granular; the byte offset never takes part in a match.
  function automatic logic [ADDR_W-3:0] word_addr(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Load forwarding search: returns the data of the youngest live entry whose
// word address matches the load address.
module store_buffer_fwd
  import pipeline_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t         i_entries [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [PTR_W:0]    i_count,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest from head so a later match overrides an earlier one;
  // this stays correct when the live window wraps past the end of the array.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < i_count) && i_entries[w_idx].valid &&
          (word_addr(i_entries[w_idx].addr) == word_addr(i_ld_addr))) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues committed stores, drains one per idle cycle
// into the single-port data memory and forwards buffered data to loads.
module store_buffer #(
  parameter  int unsigned DEPTH  = pipeline_pkg::SB_DEPTH,
  parameter  int unsigned ADDR_W = pipeline_pkg::ADDR_W,
  parameter  int unsigned DATA_W = pipeline_pkg::DATA_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_WD,
  output logic              dm_Mem_write,
  input  logic [DATA_W-1:0] dm_RD
);
  import pipeline_pkg::*;

  sb_entry_t         r_entries [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_drain;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign full    = w_full;
  assign empty   = w_empty;
  assign w_enq   = st_valid && !w_full;

  // A load owns the shared address port; otherwise the oldest entry drains.
  always_comb begin
    dm_address   = '0;
    dm_WD        = '0;
    dm_Mem_write = 1'b0;
    w_drain      = 1'b0;
    if (ld_valid) begin
      dm_address = ld_addr;
    end else if (!w_empty) begin
      dm_address   = r_entries[r_head].addr;
      dm_WD        = r_entries[r_head].data;
      dm_Mem_write = rst;
      w_drain      = 1'b1;
    end
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_ld_addr (ld_addr),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  assign ld_data = w_hit ? w_fwd_data : dm_RD;

  // Enqueue and drain never target the same slot: tail==head only when
  // the buffer is empty (no drain) or full (no enqueue).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      if (w_enq) begin
        r_entries[r_tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
        r_tail            <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared each cycle against a queue-based model of the buffer.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        full;
  logic        empty;
  logic [31:0] dm_address;
  logic [31:0] dm_WD;
  logic        dm_Mem_write;
  logic [31:0] dm_RD;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .full         (full),
    .empty        (empty),
    .dm_address   (dm_address),
    .dm_WD        (dm_WD),
    .dm_Mem_write (dm_Mem_write),
    .dm_RD        (dm_RD)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance the model.
  task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input bit lv, input logic [31:0] la, input logic [31:0] rd);
    logic [31:0] e_ld;
    bit          pre_full;
    bit          e_we;
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    dm_RD    = rd;
    e_we     = 1'b0;
    @(negedge clk);
    pre_full = (q.size() == DEPTH);
    chk("full", 32'(full), 32'(pre_full));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    e_ld = rd;
    foreach (q[i]) if (q[i].a[31:2] == la[31:2]) e_ld = q[i].d;
    chk("ld_data", ld_data, e_ld);
    if (lv) begin
      chk("dm_address(load)", dm_address, la);
      chk("dm_Mem_write(load)", 32'(dm_Mem_write), 32'd0);
    end else if (q.size() > 0) begin
      e_we = 1'b1;
      chk("dm_address(drain)", dm_address, q[0].a);
      chk("dm_WD(drain)", dm_WD, q[0].d);
      chk("dm_Mem_write(drain)", 32'(dm_Mem_write), 32'd1);
    end else begin
      chk("dm_address(idle)", dm_address, 32'd0);
      chk("dm_WD(idle)", dm_WD, 32'd0);
      chk("dm_Mem_write(idle)", 32'(dm_Mem_write), 32'd0);
    end
    @(posedge clk);
    #1;
    if (e_we) void'(q.pop_front());
    if (sv && !pre_full) q.push_back('{a: sa, d: sd});
  endtask

  task automatic reset_seq(input int unsigned n);
    rst      = 1'b0;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      dm_RD = $urandom;
      @(negedge clk);
      chk("dm_Mem_write(reset)", 32'(dm_Mem_write), 32'd0);
      @(posedge clk);
      #1;
    end
    q.delete();
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] la;
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; dm_RD = '0;

    // Reset then idle
    reset_seq(2);
    step(0, 0, 0, 0, 32'h0000_0040, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 32'h0000_0044, 32'h1234_5678);

    // Single store drains the following cycle
    step(1, 32'h8, 32'hAAAA_0001, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);

    // Two stores to one word, then a held load sees the younger value
    step(1, 32'h4, 32'h11, 1, 32'h100, 32'h0);
    step(1, 32'h4, 32'h22, 1, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h4, 32'h0);
    step(0, 0, 0, 1, 32'h6, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0);

    // Five stores under a held load: the fifth is refused
    for (int i = 0; i < 5; i++) step(1, 32'h40 + 32'(4 * i), 32'hB000 + 32'(i), 1, 32'h200, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 32'h0);

    // Interleaved stores and drains across the pointer wrap
    step(1, 32'h14, 32'h1, 1, 32'h300, 32'h0);
    step(1, 32'h18, 32'h2, 1, 32'h300, 32'h0);
    step(1, 32'h10, 32'h7, 1, 32'h300, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(1, 32'h1C, 32'h3, 1, 32'h300, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    step(1, 32'h20, 32'h4, 1, 32'h300, 32'h0);
    step(0, 0, 0, 1, 32'h10, 32'h0);
    step(1, 32'h24, 32'h5, 1, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 32'h0);

    // Reset with pending stores discards them
    for (int i = 0; i < 3; i++) step(1, 32'h80 + 32'(4 * i), 32'hC000 + 32'(i), 1, 32'h400, 32'h0);
    reset_seq(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, $urandom);

    // Random traffic over a small address window to provoke hits and overwrites
    for (int k = 0; k < 400; k++) begin
      if (k == 200) reset_seq(1);
      ra = 32'($urandom_range(0, 7)) << 2;
      la = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(bit'($urandom_range(0, 1)), ra, $urandom,
           ($urandom_range(0, 2) == 0), la, $urandom);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
